// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution datapath.
// Used by the window reader and the convolution engine.
package conv_pkg;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int K      = 5;
  localparam int RD_LAT = 1;
  localparam int WIN_W  = K * K;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } conv_state_t;

endpackage

// File: rtl/conv_win_shreg.sv
// K-column window shift register: newest column enters at the top bits.
// Clear together with load starts a fresh row with only the new column.
module conv_win_shreg
  import conv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ld,
  input  logic             i_clr,
  input  logic [K-1:0]     i_col,
  output logic [WIN_W-1:0] o_win
);

  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-K-1:0] w_keep;

  assign w_keep = i_clr ? '0 : r_win[WIN_W-1:K];
  assign o_win  = r_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win <= '0;
    end else if (i_ld) begin
      r_win <= {i_col, w_keep};
    end else if (i_clr) begin
      r_win <= '0;
    end
  end

endmodule

// File: rtl/conv_window_reader.sv
// Scans the 28x28 image store column by column and emits one 5x5
// window per cycle to the convolution engine.
module conv_window_reader
  import conv_pkg::*;
(
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             cal_start,
  output logic [4:0]       data_rd_addr,
  output logic [4:0]       conv_row_cnt,
  input  logic [K-1:0]     col_data,
  output logic [WIN_W-1:0] win_data,
  output logic [4:0]       win_row,
  output logic [4:0]       win_col,
  output logic             win_vld,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [4:0] ADDR_LAST = 5'(IMG_W - 1);
  localparam logic [4:0] ROW_LAST  = 5'(IMG_H - K);
  localparam logic [4:0] COL_FIRST = 5'(K - 1);
  localparam logic [2:0] DR_LAST   = 3'(RD_LAT - 1);

  conv_state_t r_state;
  logic [4:0]  r_addr;
  logic [4:0]  r_row;
  logic [2:0]  r_dcnt;
  logic        r_busy;
  logic        r_done;

  logic [RD_LAT-1:0]      r_pv;
  logic [RD_LAT-1:0][4:0] r_pc;
  logic [RD_LAT-1:0][4:0] r_pr;

  logic       r_vld;
  logic [4:0] r_wrow;
  logic [4:0] r_wcol;

  logic       w_cap;
  logic [4:0] w_cc;
  logic [4:0] w_cr;
  logic       w_clr;

  assign w_cap = r_pv[RD_LAT-1];
  assign w_cc  = r_pc[RD_LAT-1];
  assign w_cr  = r_pr[RD_LAT-1];
  assign w_clr = w_cap && (w_cc == '0);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_row   <= '0;
      r_dcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cal_start) begin
            r_state <= READ;
            r_addr  <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
          end
        end
        READ: begin
          if (r_addr == ADDR_LAST) begin
            r_state <= DRAIN;
            r_dcnt  <= '0;
          end else begin
            r_addr <= r_addr + 5'd1;
          end
        end
        DRAIN: begin
          if (r_dcnt == DR_LAST) begin
            r_addr <= '0;
            if (r_row == ROW_LAST) begin
              r_state <= DONE;
            end else begin
              r_state <= READ;
              r_row   <= r_row + 5'd1;
            end
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag each issued address so the slice is captured RD_LAT cycles later
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_pv <= '0;
      r_pc <= '0;
      r_pr <= '0;
    end else begin
      r_pv[0] <= (r_state == READ);
      r_pc[0] <= r_addr;
      r_pr[0] <= r_row;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
        r_pr[i] <= r_pr[i-1];
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_vld  <= 1'b0;
      r_wrow <= '0;
      r_wcol <= '0;
    end else begin
      r_vld <= w_cap && (w_cc >= COL_FIRST);
      if (w_cap && (w_cc >= COL_FIRST)) begin
        r_wrow <= w_cr;
        r_wcol <= w_cc - COL_FIRST;
      end
    end
  end

  conv_win_shreg u_shreg (
    .i_clk   (sclk),
    .i_rst_n (s_rst_n),
    .i_ld    (w_cap),
    .i_clr   (w_clr),
    .i_col   (col_data),
    .o_win   (win_data)
  );

  assign data_rd_addr = r_addr;
  assign conv_row_cnt = r_row;
  assign win_vld      = r_vld;
  assign win_row      = r_wrow;
  assign win_col      = r_wcol;
  assign busy         = r_busy;
  assign frame_done   = r_done;

endmodule
